// File: rtl/acc_core_mc.sv
// Parametrised multi-cycle accumulator core with req/ack instruction and data memory ports.
// Optional performance counters are enabled by defining ACC_CORE_MC_PERF_CNT_EN.
module acc_core_mc #(
  parameter int unsigned W    = 8,
  parameter int unsigned D    = 12,
  parameter int unsigned NREG = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         done,
  output logic [D-1:0] pc,
  output logic         imem_req,
  output logic [D-1:0] imem_addr,
  input  logic [8:0]   imem_rdata,
  input  logic         imem_ack,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [W-1:0] dmem_addr,
  output logic [W-1:0] dmem_wdata,
  input  logic [W-1:0] dmem_rdata,
  input  logic         dmem_ack,
  output logic [31:0]  cyc_cnt,
  output logic [31:0]  ret_cnt
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StHalt} state_e;

  state_e         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [8:0]     ir_q;
  logic [W-1:0]   regs_q [NREG];
  logic           z_q, z_d, c_q, c_d;
  logic           ir_load, wr_en, upd_z, retire, restart;
  logic [3:0]     wr_idx;
  logic [W-1:0]   wr_val;

  logic           is_li;
  logic [3:0]     op, n;
  logic [W-1:0]   r0, rn, li_val;
  logic [W:0]     sum, diff;
  logic [D-1:0]   jr_off;

  assign is_li  = ir_q[8];
  assign op     = ir_q[7:4];
  assign n      = ir_q[3:0];
  assign r0     = regs_q[0];
  assign li_val = W'(ir_q[7:0]);
  assign sum    = {1'b0, r0} + {1'b0, rn};
  assign diff   = {1'b0, r0} - {1'b0, rn};
  assign jr_off = D'($signed(ir_q[3:0]));

  // Unimplemented register indices read as zero.
  always_comb begin
    rn = '0;
    if (32'(n) < NREG) rn = regs_q[n[IW-1:0]];
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    z_d      = z_q;
    c_d      = c_q;
    ir_load  = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = 4'd0;
    wr_val   = r0;
    upd_z    = 1'b0;
    retire   = 1'b0;
    restart  = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StFetch;
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        pc_d    = pc_q + 1'b1;
        state_d = StFetch;
        retire  = 1'b1;
        if (is_li) begin
          wr_en  = 1'b1;
          wr_val = li_val;
          upd_z  = 1'b1;
        end else begin
          unique case (op)
            4'h0: begin wr_en = 1'b1; wr_idx = n; wr_val = r0; end
            4'h1: begin wr_en = 1'b1; wr_val = rn; upd_z = 1'b1; end
            4'h2: begin wr_en = 1'b1; wr_val = sum[W-1:0]; c_d = sum[W]; upd_z = 1'b1; end
            4'h3: begin wr_en = 1'b1; wr_val = diff[W-1:0]; c_d = ~diff[W]; upd_z = 1'b1; end
            4'h4: begin wr_en = 1'b1; wr_val = r0 & rn; upd_z = 1'b1; end
            4'h5: begin wr_en = 1'b1; wr_val = r0 ^ rn; upd_z = 1'b1; end
            4'h6: begin wr_en = 1'b1; wr_val = {r0[W-2:0], c_q}; c_d = r0[W-1]; upd_z = 1'b1; end
            4'h7: begin wr_en = 1'b1; wr_val = {c_q, r0[W-1:1]}; c_d = r0[0]; upd_z = 1'b1; end
            4'h8, 4'h9: begin state_d = StMem; retire = 1'b0; end
            4'hA: if (!z_q) pc_d = D'(rn);
            4'hB: if (z_q) pc_d = D'(rn);
            4'hC: pc_d = pc_q + jr_off;
            4'hD: c_d = 1'b0;
            4'hE: ;
            4'hF: begin pc_d = pc_q; state_d = StHalt; end
            default: ;
          endcase
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d = StFetch;
          retire  = 1'b1;
          if (op == 4'h8) begin
            wr_en  = 1'b1;
            wr_val = dmem_rdata;
            upd_z  = 1'b1;
          end
        end
      end
      StHalt: begin
        done = 1'b1;
        if (start) begin
          pc_d    = '0;
          state_d = StFetch;
          restart = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (upd_z) z_d = (wr_val == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      if (ir_load) ir_q <= imem_rdata;
      if (wr_en && (32'(wr_idx) < NREG)) regs_q[wr_idx[IW-1:0]] <= wr_val;
    end
  end

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign dmem_we    = (op == 4'h9);
  assign dmem_addr  = rn;
  assign dmem_wdata = r0;

`ifdef ACC_CORE_MC_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else if (restart) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != StIdle && state_q != StHalt) cyc_q <= cyc_q + 1'b1;
      if (retire) ret_q <= ret_q + 1'b1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`else
  logic unused_perf;
  assign unused_perf = retire ^ restart;
  assign cyc_cnt     = '0;
  assign ret_cnt     = '0;
`endif

endmodule

// File: tb/tb_acc_core_mc.sv
// Directed testbench for acc_core_mc with behavioural ROM and data memory models.
module tb_acc_core_mc;
  logic        clk, reset, start, done;
  logic [11:0] pc, imem_addr;
  logic        imem_req, imem_ack;
  logic [8:0]  imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] cyc_cnt, ret_cnt;

  logic [8:0]  rom  [4096];
  logic [7:0]  dmem [256];
  logic        ihold = 1'b0;
  int          dwait = 0;
  int          dcnt  = 0;
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  logic        in_txn = 1'b0;
  int          cur_len = 0, last_len = 0, stab_err = 0;
  logic [7:0]  s_addr, s_wdata;
  logic        s_we;

  acc_core_mc dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .cyc_cnt    (cyc_cnt),
    .ret_cnt    (ret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack   = imem_req && !ihold;
  assign imem_rdata = rom[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt == dwait);
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else dcnt <= 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  // Track how long each data request is held and whether its payload moves before ack.
  always @(negedge clk) begin
    if (dmem_req) begin
      if (in_txn && (dmem_addr !== s_addr || dmem_wdata !== s_wdata || dmem_we !== s_we))
        stab_err <= stab_err + 1;
      s_addr  <= dmem_addr;
      s_wdata <= dmem_wdata;
      s_we    <= dmem_we;
      if (dmem_ack) begin
        last_len <= cur_len + 1;
        cur_len  <= 0;
        in_txn   <= 1'b0;
      end else begin
        cur_len <= cur_len + 1;
        in_txn  <= 1'b1;
      end
    end else begin
      cur_len <= 0;
      in_txn  <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 9'h0F0;
  endtask

  // Pulse start, then count cycles until done (bounded).
  task automatic run(output int ncyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef ACC_CORE_MC_PERF_CNT_EN
    check("cyc_clear", cyc_cnt, 32'd0);
    check("ret_clear", ret_cnt, 32'd0);
`endif
    ncyc = 0;
    while (!done && ncyc < 300) begin
      @(posedge clk);
      #1;
      ncyc++;
    end
    if (!done) check("run_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    clr_rom();
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done, 1'b0);
    check("rst_pc", pc, 12'h000);
    check("rst_ireq", imem_req, 1'b0);
    check("rst_dreq", dmem_req, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // LI 5; MOV R3; LI 3; ADD R3; HALT
    rom[0] = 9'h105; rom[1] = 9'h003; rom[2] = 9'h103; rom[3] = 9'h023; rom[4] = 9'h0F0;
    run(cyc);
    check("add_cycles", cyc, 32'd10);
    check("add_r0", dut.regs_q[0], 8'h08);
    check("add_r3", dut.regs_q[3], 8'h05);
    check("add_z", dut.z_q, 1'b0);
    check("add_c", dut.c_q, 1'b0);
    check("add_done", done, 1'b1);
    check("add_pc", pc, 12'h004);
    repeat (3) @(posedge clk);
    #1;
    check("halt_pc_hold", pc, 12'h004);
`ifdef ACC_CORE_MC_PERF_CNT_EN
    check("perf_ret", ret_cnt, 32'd5);
    check("perf_cyc", cyc_cnt, 32'd10);
`else
    check("perf_cyc_tied", cyc_cnt, 32'd0);
    check("perf_ret_tied", ret_cnt, 32'd0);
`endif

    // LI 7; MOV R2; SUB R0; BZ R2 -> pc 7 (HALT)
    clr_rom();
    rom[0] = 9'h107; rom[1] = 9'h002; rom[2] = 9'h030; rom[3] = 9'h0B2;
    run(cyc);
    check("bz_pc", pc, 12'h007);
    check("bz_z", dut.z_q, 1'b1);
    check("sub_c", dut.c_q, 1'b1);
    check("sub_r0", dut.regs_q[0], 8'h00);
    rom[3] = 9'h0A2;
    run(cyc);
    check("bnz_pc", pc, 12'h004);

    // LI 20; MOV R1; LI 5A; ST R1; LI 0; LD R1; HALT with 3-cycle data latency
    clr_rom();
    dwait = 3;
    rom[0] = 9'h120; rom[1] = 9'h001; rom[2] = 9'h15A; rom[3] = 9'h091;
    rom[4] = 9'h100; rom[5] = 9'h081;
    run(cyc);
    check("st_mem", dmem[8'h20], 8'h5A);
    check("ld_r0", dut.regs_q[0], 8'h5A);
    check("ld_z", dut.z_q, 1'b0);
    check("ld_pc", pc, 12'h006);
    check("dreq_len", last_len, 32'd4);
    check("dreq_stable", stab_err, 32'd0);
    dwait = 0;

    // JR -1 at pc 0 wraps to 0xFFF
    clr_rom();
    rom[0] = 9'h0CF;
    run(cyc);
    check("jr_wrap_pc", pc, 12'hFFF);

    // LI 1; MOV R5; LI FF; ADD R5 -> 0 with carry
    clr_rom();
    rom[0] = 9'h101; rom[1] = 9'h005; rom[2] = 9'h1FF; rom[3] = 9'h025;
    run(cyc);
    check("ovf_r0", dut.regs_q[0], 8'h00);
    check("ovf_c", dut.c_q, 1'b1);
    check("ovf_z", dut.z_q, 1'b1);

    // CLC; LI 3C; MOV R6; LI 96; XOR R6; SHL; SHL; SHR; AND R6
    clr_rom();
    rom[0] = 9'h0D0; rom[1] = 9'h13C; rom[2] = 9'h006; rom[3] = 9'h196; rom[4] = 9'h056;
    rom[5] = 9'h060; rom[6] = 9'h060; rom[7] = 9'h070; rom[8] = 9'h046;
    run(cyc);
    check("logic_r0", dut.regs_q[0], 8'h14);
    check("logic_c", dut.c_q, 1'b1);
    check("logic_z", dut.z_q, 1'b0);

    // Reset while a fetch is stalled at pc 2
    clr_rom();
    rom[0] = 9'h105; rom[1] = 9'h003; rom[2] = 9'h103; rom[3] = 9'h023;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(imem_req && pc == 12'h002) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("stall_reach", pc, 12'h002);
    ihold = 1'b1;
    @(posedge clk);
    #1;
    check("stall_ireq", imem_req, 1'b1);
    check("stall_addr", imem_addr, 12'h002);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_ireq", imem_req, 1'b0);
    check("mid_rst_pc", pc, 12'h000);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_r3", dut.regs_q[3], 8'h00);
    @(negedge clk);
    reset = 1'b1;
    ihold = 1'b0;
    @(negedge clk);
    check("post_rst_idle", imem_req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
